// File: rtl/sgdmac_cfg_pkg.sv
// Shared register map, channel state type and default version for the
// multi-channel scatter-gather DMA configuration block.
package sgdmac_cfg_pkg;

  localparam logic [11:0] VERSION_OFS  = 12'h000;
  localparam logic [11:0] NCH_OFS      = 12'h004;
  localparam logic [11:0] IRQ_STAT_OFS = 12'h008;
  localparam logic [11:0] IRQ_MASK_OFS = 12'h00C;
  localparam logic [11:0] CH_BASE      = 12'h100;
  localparam logic [11:0] CH_STRIDE    = 12'h010;
  localparam logic [3:0]  DESC_OFS     = 4'h0;
  localparam logic [3:0]  CTRL_OFS     = 4'h4;
  localparam logic [3:0]  STAT_OFS     = 4'h8;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0201_2025;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ch_state_e;

endpackage

// File: rtl/sgdmac_cfg_ch.sv
// One DMA channel: descriptor pointer, IDLE/BUSY tracking, start pulse and
// done flag; reports rejected writes back to the APB decoder.
module sgdmac_cfg_ch
  import sgdmac_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        desc_wr,
  input  logic [31:0] wdata,
  input  logic        start_wr,
  input  logic        done_in,
  output logic [31:0] desc_ptr,
  output logic        start,
  output logic        busy,
  output logic        done_flag,
  output logic        done_evt,
  output logic        reject
);

  ch_state_e   state_r;
  ch_state_e   state_nxt_s;
  logic        accept_s;
  logic        done_evt_s;
  logic [31:0] desc_ptr_r;
  logic        start_r;
  logic        done_r;

  // Next-state logic; both start and done are judged against the pre-edge state.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    done_evt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_wr) begin
          state_nxt_s = BUSY;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (done_in) begin
          state_nxt_s = IDLE;
          done_evt_s  = 1'b1;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Channel state, pointer, start pulse and done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      desc_ptr_r <= 32'h0000_0000;
      start_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      start_r <= accept_s;
      if (desc_wr && (state_r == IDLE)) begin
        desc_ptr_r <= wdata;
      end
      if (accept_s) begin
        done_r <= 1'b0;
      end else if (done_evt_s) begin
        done_r <= 1'b1;
      end
    end
  end

  assign desc_ptr  = desc_ptr_r;
  assign start     = start_r;
  assign busy      = (state_r == BUSY);
  assign done_flag = done_r;
  assign done_evt  = done_evt_s;
  assign reject    = (state_r == BUSY) & (start_wr | desc_wr);

endmodule

// File: rtl/sgdmac_cfg_mc.sv
// Multi-channel APB config/status block: address decode, read mux, error
// signalling and (with SGDMAC_IRQ_EN defined) interrupt status/mask.
module sgdmac_cfg_mc
  import sgdmac_cfg_pkg::*;
#(
  parameter int          CH_CNT  = 4,
  parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [11:0]           paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic                  pready_o,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  output logic [32*CH_CNT-1:0]  start_pointer_o,
  output logic [CH_CNT-1:0]     start_o,
  input  logic [CH_CNT-1:0]     done_i,
  output logic                  irq_o
);

  logic              access_s;
  logic              wr_s;
  logic              aligned_s;
  logic              glob_hit_s;
  logic              ch_hit_s;
  logic [7:0]        ch_idx_s;
  logic [3:0]        ch_sel_s;
  logic [3:0]        ofs_s;
  logic [CH_CNT-1:0] desc_wr_s;
  logic [CH_CNT-1:0] start_wr_s;
  logic [CH_CNT-1:0] busy_s;
  logic [CH_CNT-1:0] done_flag_s;
  logic [CH_CNT-1:0] done_evt_s;
  logic [CH_CNT-1:0] reject_s;
  logic [31:0]       desc_ptr_s [CH_CNT];
  logic [31:0]       sel_ptr_s;
  logic              sel_busy_s;
  logic              sel_done_s;
  logic [CH_CNT-1:0] irq_stat_s;
  logic [CH_CNT-1:0] irq_mask_s;
  logic [31:0]       rdata_s;
  logic              err_s;
  logic [31:0]       prdata_r;

  assign access_s   = psel_i & penable_i;
  assign wr_s       = access_s & pwrite_i;
  assign ofs_s      = paddr_i[3:0];
  assign aligned_s  = (paddr_i[1:0] == 2'b00);
  assign glob_hit_s = (paddr_i[11:4] == 8'h00) & aligned_s;
  assign ch_idx_s   = paddr_i[11:4] - CH_BASE[11:4];
  assign ch_sel_s   = ch_idx_s[3:0];
  assign ch_hit_s   = (paddr_i[11:8] != 4'h0) & aligned_s &
                      (ch_idx_s < 8'(CH_CNT)) & (ofs_s != 4'hC);

  for (genvar n = 0; n < CH_CNT; n++) begin : g_ch
    assign desc_wr_s[n]  = wr_s & ch_hit_s & (ch_sel_s == 4'(n)) & (ofs_s == DESC_OFS);
    assign start_wr_s[n] = wr_s & ch_hit_s & (ch_sel_s == 4'(n)) & (ofs_s == CTRL_OFS) & pwdata_i[0];

    sgdmac_cfg_ch u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .desc_wr   (desc_wr_s[n]),
      .wdata     (pwdata_i),
      .start_wr  (start_wr_s[n]),
      .done_in   (done_i[n]),
      .desc_ptr  (desc_ptr_s[n]),
      .start     (start_o[n]),
      .busy      (busy_s[n]),
      .done_flag (done_flag_s[n]),
      .done_evt  (done_evt_s[n]),
      .reject    (reject_s[n])
    );

    assign start_pointer_o[32*n +: 32] = desc_ptr_s[n];
  end

`ifdef SGDMAC_IRQ_EN
  logic [CH_CNT-1:0] irq_stat_r;
  logic [CH_CNT-1:0] irq_mask_r;
  logic [CH_CNT-1:0] irq_stat_nxt_s;
  logic [CH_CNT-1:0] irq_mask_nxt_s;
  logic              irq_r;

  // W1C clear first, then OR in completions so a same-cycle done wins.
  always_comb begin
    irq_stat_nxt_s = irq_stat_r;
    irq_mask_nxt_s = irq_mask_r;
    if (wr_s && glob_hit_s && (ofs_s == IRQ_STAT_OFS[3:0])) begin
      irq_stat_nxt_s = irq_stat_r & ~pwdata_i[CH_CNT-1:0];
    end else begin
      irq_stat_nxt_s = irq_stat_r;
    end
    irq_stat_nxt_s = irq_stat_nxt_s | done_evt_s;
    if (wr_s && glob_hit_s && (ofs_s == IRQ_MASK_OFS[3:0])) begin
      irq_mask_nxt_s = pwdata_i[CH_CNT-1:0];
    end else begin
      irq_mask_nxt_s = irq_mask_r;
    end
  end

  // Interrupt status, mask and registered interrupt line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat_r <= '0;
      irq_mask_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      irq_stat_r <= irq_stat_nxt_s;
      irq_mask_r <= irq_mask_nxt_s;
      irq_r      <= |(irq_stat_nxt_s & irq_mask_nxt_s);
    end
  end

  assign irq_stat_s = irq_stat_r;
  assign irq_mask_s = irq_mask_r;
  assign irq_o      = irq_r;
`else
  logic unused_irq_s;
  assign unused_irq_s = ^done_evt_s;
  assign irq_stat_s   = '0;
  assign irq_mask_s   = '0;
  assign irq_o        = 1'b0;
`endif

  // AND-OR select of the addressed channel's readable state.
  always_comb begin
    sel_ptr_s  = 32'h0000_0000;
    sel_busy_s = 1'b0;
    sel_done_s = 1'b0;
    for (int n = 0; n < CH_CNT; n++) begin
      sel_ptr_s  = sel_ptr_s  | (desc_ptr_s[n] & {32{ch_sel_s == 4'(n)}});
      sel_busy_s = sel_busy_s | (busy_s[n] & (ch_sel_s == 4'(n)));
      sel_done_s = sel_done_s | (done_flag_s[n] & (ch_sel_s == 4'(n)));
    end
  end

  // Read mux and error decode; unmapped locations read 0.
  always_comb begin
    rdata_s = 32'h0000_0000;
    err_s   = 1'b0;
    if (glob_hit_s) begin
      case (ofs_s)
        VERSION_OFS[3:0]: begin
          rdata_s = VERSION;
          err_s   = pwrite_i;
        end
        NCH_OFS[3:0]: begin
          rdata_s = 32'(CH_CNT);
          err_s   = pwrite_i;
        end
        IRQ_STAT_OFS[3:0]: rdata_s = 32'(irq_stat_s);
        IRQ_MASK_OFS[3:0]: rdata_s = 32'(irq_mask_s);
        default:           err_s   = 1'b1;
      endcase
    end else if (ch_hit_s) begin
      case (ofs_s)
        DESC_OFS: begin
          rdata_s = sel_ptr_s;
          err_s   = |reject_s;
        end
        CTRL_OFS: err_s = |reject_s;
        STAT_OFS: begin
          rdata_s = {30'h0000_0000, sel_done_s, sel_busy_s};
          err_s   = pwrite_i;
        end
        default:  err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b1;
    end
  end

  // Read data captured at the end of the setup phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_r <= 32'h0000_0000;
    end else if (psel_i && !penable_i) begin
      prdata_r <= rdata_s;
    end
  end

  assign prdata_o  = prdata_r;
  assign pready_o  = 1'b1;
  assign pslverr_o = access_s & err_s;

endmodule

// File: tb/tb_sgdmac_cfg_mc.sv
// Scoreboard bench for sgdmac_cfg_mc: APB responses and start pulses are
// queued at issue time and checked by an independent monitor.
module tb_sgdmac_cfg_mc;

  localparam int CH_CNT = 4;
`ifdef SGDMAC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic                 clk     = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 psel    = 1'b0;
  logic                 penable = 1'b0;
  logic                 pwrite  = 1'b0;
  logic [11:0]          paddr   = 12'h000;
  logic [31:0]          pwdata  = 32'h0;
  logic [CH_CNT-1:0]    done_i  = '0;
  logic                 pready;
  logic [31:0]          prdata;
  logic                 pslverr;
  logic [32*CH_CNT-1:0] start_pointer;
  logic [CH_CNT-1:0]    start_o;
  logic                 irq;

  sgdmac_cfg_mc #(.CH_CNT(CH_CNT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .psel_i          (psel),
    .penable_i       (penable),
    .pwrite_i        (pwrite),
    .paddr_i         (paddr),
    .pwdata_i        (pwdata),
    .pready_o        (pready),
    .prdata_o        (prdata),
    .pslverr_o       (pslverr),
    .start_pointer_o (start_pointer),
    .start_o         (start_o),
    .done_i          (done_i),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
    logic [11:0] addr;
  } apb_exp_t;

  apb_exp_t          apb_q[$];
  logic [CH_CNT-1:0] start_q[$];
  apb_exp_t          e;
  logic [CH_CNT-1:0] se;
  int                n_chk = 0;
  int                n_bad = 0;
  logic [31:0]       irq2;

  // Monitor: compare every access phase and every start pulse against the queues.
  always @(negedge clk) begin
    if (rst_n && psel && penable) begin
      n_chk++;
      if (apb_q.size() == 0) begin
        n_bad++;
        $display("FAIL apb_unexpected addr=%h", paddr);
      end else begin
        e = apb_q.pop_front();
        if (pslverr !== e.err || (e.is_read && prdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL apb addr=%h got rdata=%h err=%b want rdata=%h err=%b",
                   e.addr, prdata, pslverr, e.rdata, e.err);
        end
      end
    end
    if (rst_n && start_o !== '0) begin
      n_chk++;
      if (start_q.size() == 0) begin
        n_bad++;
        $display("FAIL start_unexpected got=%b", start_o);
      end else begin
        se = start_q.pop_front();
        if (start_o !== se) begin
          n_bad++;
          $display("FAIL start got=%b want=%b", start_o, se);
        end
      end
    end
  end

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input logic [CH_CNT-1:0] dn);
    apb_exp_t x;
    x.is_read = ~wr;
    x.rdata   = exp_rd;
    x.err     = exp_err;
    x.addr    = a;
    apb_q.push_back(x);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1; done_i = dn;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done_i = '0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp_rd, input logic exp_err);
    apb(1'b0, a, 32'h0, exp_rd, exp_err, '0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err);
    apb(1'b1, a, d, 32'h0, exp_err, '0);
  endtask

  task automatic pulse_done(input logic [CH_CNT-1:0] dn);
    @(posedge clk); #1; done_i = dn;
    @(posedge clk); #1; done_i = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    irq2 = IRQ_EN ? 32'h2 : 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_start", 32'(start_o), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    chk("rst_ptr", 32'(|start_pointer), 32'h0);
    rst_n = 1'b1;

    rd(12'h000, 32'h0201_2025, 1'b0);
    rd(12'h004, 32'h4, 1'b0);
    rd(12'h108, 32'h0, 1'b0);

    // channel 1 start
    wr(12'h110, 32'h8000_1000, 1'b0);
    start_q.push_back(4'b0010);
    wr(12'h114, 32'h1, 1'b0);
    chk("ptr1", start_pointer[63:32], 32'h8000_1000);
    rd(12'h118, 32'h1, 1'b0);

    // rejected writes while busy
    wr(12'h114, 32'h1, 1'b1);
    wr(12'h110, 32'hDEAD_BEEF, 1'b1);
    chk("ptr1_held", start_pointer[63:32], 32'h8000_1000);
    rd(12'h110, 32'h8000_1000, 1'b0);
    pulse_done(4'b0010);
    rd(12'h118, 32'h2, 1'b0);
    rd(12'h008, irq2, 1'b0);

    // mask, clear, then done raises irq
    wr(12'h00C, 32'h2, 1'b0);
    rd(12'h00C, irq2, 1'b0);
    wr(12'h008, 32'h2, 1'b0);
    chk("irq_cleared0", 32'(irq), 32'h0);
    start_q.push_back(4'b0010);
    wr(12'h114, 32'h1, 1'b0);
    pulse_done(4'b0010);
    chk("irq_set", 32'(irq), 32'(IRQ_EN));
    rd(12'h008, irq2, 1'b0);

    // W1C coinciding with done: set wins
    start_q.push_back(4'b0010);
    wr(12'h114, 32'h1, 1'b0);
    rd(12'h118, 32'h1, 1'b0);
    apb(1'b1, 12'h008, 32'h2, 32'h0, 1'b0, 4'b0010);
    chk("irq_setwins", 32'(irq), 32'(IRQ_EN));
    rd(12'h008, irq2, 1'b0);
    rd(12'h118, 32'h2, 1'b0);
    wr(12'h008, 32'h2, 1'b0);
    chk("irq_cleared1", 32'(irq), 32'h0);
    rd(12'h008, 32'h0, 1'b0);

    // start coinciding with done is rejected; restart right after is accepted
    start_q.push_back(4'b0010);
    wr(12'h114, 32'h1, 1'b0);
    apb(1'b1, 12'h114, 32'h1, 32'h0, 1'b1, 4'b0010);
    rd(12'h118, 32'h2, 1'b0);
    start_q.push_back(4'b0010);
    wr(12'h114, 32'h1, 1'b0);
    rd(12'h118, 32'h1, 1'b0);
    pulse_done(4'b0010);
    rd(12'h118, 32'h2, 1'b0);
    wr(12'h008, 32'hF, 1'b0);
    chk("irq_cleared2", 32'(irq), 32'h0);

    // CTRL writes with bit0 clear do nothing
    wr(12'h104, 32'h0, 1'b0);
    wr(12'h114, 32'h2, 1'b0);
    rd(12'h108, 32'h0, 1'b0);

    // unmapped and read-only accesses
    rd(12'h140, 32'h0, 1'b1);
    rd(12'h10C, 32'h0, 1'b1);
    wr(12'h118, 32'h5, 1'b1);
    wr(12'h000, 32'h1, 1'b1);
    wr(12'h004, 32'h1, 1'b1);
    rd(12'h010, 32'h0, 1'b1);
    rd(12'h004, 32'h4, 1'b0);
    wr(12'h130, 32'h1234_5678, 1'b0);
    rd(12'h130, 32'h1234_5678, 1'b0);

    // reset while channel 2 busy, in the middle of a transfer
    start_q.push_back(4'b0100);
    wr(12'h124, 32'h1, 1'b0);
    rd(12'h128, 32'h1, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h120;
    #3 rst_n = 1'b0;
    #3;
    chk("midrst_start", 32'(start_o), 32'h0);
    chk("midrst_prdata", prdata, 32'h0);
    chk("midrst_ptr", 32'(|start_pointer), 32'h0);
    @(posedge clk); #1;
    psel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_done(4'b0100);
    rd(12'h128, 32'h0, 1'b0);
    rd(12'h008, 32'h0, 1'b0);
    rd(12'h00C, 32'h0, 1'b0);
    chk("post_rst_irq", 32'(irq), 32'h0);
    rd(12'h110, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("apb_q_empty", 32'(apb_q.size()), 32'h0);
    chk("start_q_empty", 32'(start_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
